// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants and MAC state encoding for the neuron datapath.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package nn_fixed_pkg;

  localparam int DATA_W            = 8;
  localparam int FRAC_BITS_DEFAULT = 4;
  localparam int PROD_W            = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } mac_state_e;

  // Accumulator width that can hold n full-width products plus a shifted bias.
  function automatic int acc_width(input int n);
    return PROD_W + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/neuron_mac_fit.sv
// Scales the accumulator down to Q4.4 (floor) and fits it into 8 bits.
// Latency: combinational. Backpressure: not applicable.
// NEURON_MAC_SAT_EN defined: saturate to [-128,127]; undefined: keep low 8 bits.
module neuron_mac_fit
  import nn_fixed_pkg::*;
#(
  parameter int ACC_W     = 19,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic        [DATA_W-1:0] z_o
);

  logic signed [ACC_W-1:0] shifted;

  // Arithmetic shift drops the fraction bits toward negative infinity.
  assign shifted = acc_i >>> FRAC_BITS;

`ifdef NEURON_MAC_SAT_EN
  logic fits;

  // Value fits in 8 bits when everything above bit 7 is a copy of bit 7.
  assign fits = (shifted[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){shifted[DATA_W-1]}});

  // Clamp to the most negative / most positive 8-bit code on overflow.
  always_comb begin
    z_o = shifted[DATA_W-1:0];
    if (!fits) begin
      z_o = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_high_bits;

  // Two's-complement wrap: the high bits are intentionally discarded.
  assign z_o              = shifted[DATA_W-1:0];
  assign unused_high_bits = ^shifted[ACC_W-1:DATA_W];
`endif

endmodule

// File: rtl/neuron_mac.sv
// Neuron pre-activation: z = fit8((bias<<<F + sum x*w) >>> F) over N_INPUTS pairs.
// Latency: z_value valid 1 cycle after the last accepted pair.
// Backpressure: in_ready low while a result waits in HOLD; released by out_ready. NEURON_MAC_SAT_EN selects saturation.
module neuron_mac
  import nn_fixed_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x,
  input  logic signed [7:0] w,
  input  logic signed [7:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] z_value
);

  localparam int ACC_W = acc_width(N_INPUTS);
  localparam int CNT_W = $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  mac_state_e               state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        z_q, z_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_term;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0]        fit_z;

  // Full-precision product; bias is promoted to the product's Q8.8 scale.
  assign prod      = x * w;
  assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_term = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_BITS;

  // First pair of an evaluation restarts from the bias instead of the old sum.
  assign acc_base = (count_q == '0) ? bias_term : acc_q;
  assign acc_next = acc_base + prod_ext;

  neuron_mac_fit #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_fit (
    .acc_i (acc_next),
    .z_o   (fit_z)
  );

  // Next-state, handshake outputs and datapath updates.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    z_d       = z_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_next;
          if (count_q == CNT_LAST) begin
            count_d = '0;
            z_d     = fit_z;
            state_d = ST_HOLD;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      count_q <= '0;
      acc_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
    end
  end

  assign z_value = z_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed bench for neuron_mac against an arithmetic model.
// Latency: checks result 1 cycle after the last accepted pair.
// Backpressure: holds out_ready low for random stretches while offering junk pairs.
module tb_neuron_mac;

  localparam int N    = 4;
  localparam int FRAC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] w;
  logic [7:0] bias;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z_value;

  int n_checks = 0;
  int n_errors = 0;

  neuron_mac #(
    .N_INPUTS  (N),
    .FRAC_BITS (FRAC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_value   (z_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer sum, floor division by 2^FRAC, then 8-bit fit.
  function automatic int model_z(input byte b, input byte xs[N], input byte ws[N]);
    int s;
    s = int'(b) * (1 << FRAC);
    for (int i = 0; i < N; i++) s += int'(xs[i]) * int'(ws[i]);
    s = s >>> FRAC;
`ifdef NEURON_MAC_SAT_EN
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`endif
    return s & 255;
  endfunction

  // Offer N pairs with random idle gaps; only the first pair carries the real bias.
  task automatic feed_pairs(input string tag, input byte b, input byte xs[N], input byte ws[N]);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid  = 1'b0;
        x         = 8'($urandom);
        w         = 8'($urandom);
        bias      = 8'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      in_valid  = 1'b1;
      x         = xs[i];
      w         = ws[i];
      bias      = (i == 0) ? b : 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic run_eval(input string tag, input byte b, input byte xs[N], input byte ws[N],
                          input int exp, input int stall);
    feed_pairs(tag, b, xs, ws);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_hold_rdy"}, in_ready, 0);
    check({tag, "_z"}, z_value, exp);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      x        = 8'($urandom);
      w        = 8'($urandom);
      bias     = 8'($urandom);
      @(posedge clk); #1;
      check({tag, "_stall_vld"}, out_valid, 1);
      check({tag, "_stall_rdy"}, in_ready, 0);
      check({tag, "_stall_z"}, z_value, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rel_vld"}, out_valid, 0);
    check({tag, "_rel_rdy"}, in_ready, 1);
    check({tag, "_retain_z"}, z_value, exp);
  endtask

  initial begin
    byte xs[N];
    byte ws[N];
    byte b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    w         = '0;
    bias      = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z_value, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    xs = '{8'h10, 8'h10, 8'h10, 8'h10};
    ws = '{8'h10, 8'h10, 8'h10, 8'h10};
    run_eval("basic", 8'h00, xs, ws, 8'h40, 3);

    xs = '{8'h18, 8'h18, 8'h18, 8'h18};
    ws = '{8'h08, 8'h08, 8'h08, 8'h08};
    run_eval("bias_frac", 8'h10, xs, ws, 8'h40, 1);

    xs = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    ws = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
`ifdef NEURON_MAC_SAT_EN
    run_eval("ovf_pos", 8'h00, xs, ws, 8'h7F, 0);
`else
    run_eval("ovf_pos", 8'h00, xs, ws, 8'hC0, 0);
`endif

    xs = '{8'h80, 8'h80, 8'h80, 8'h80};
    ws = '{8'h10, 8'h10, 8'h10, 8'h10};
`ifdef NEURON_MAC_SAT_EN
    run_eval("ovf_neg", 8'h00, xs, ws, 8'h80, 0);
`else
    run_eval("ovf_neg", 8'h00, xs, ws, 8'h00, 0);
`endif

    xs = '{8'hFF, 8'h00, 8'h00, 8'h00};
    ws = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_eval("floor", 8'h00, xs, ws, 8'hFF, 2);

    // Reset after two accepted pairs must drop the partial sum.
    in_valid = 1'b1;
    x        = 8'h10;
    w        = 8'h10;
    bias     = 8'h30;
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_z", z_value, 0);
    check("mid_rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xs = '{8'h10, 8'h10, 8'h10, 8'h10};
    ws = '{8'h10, 8'h10, 8'h10, 8'h10};
    run_eval("after_rst", 8'h00, xs, ws, 8'h40, 1);

    // Reset while a result is held.
    xs = '{8'h20, 8'h20, 8'h20, 8'h20};
    ws = '{8'h10, 8'h10, 8'h10, 8'h10};
    feed_pairs("hold_rst", 8'h00, xs, ws);
    check("hold_rst_pre_vld", out_valid, 1);
    check("hold_rst_pre_z", z_value, 8'h80 & model_z(8'h00, xs, ws) | model_z(8'h00, xs, ws));
    rst_n = 1'b0;
    #2;
    check("hold_rst_vld", out_valid, 0);
    check("hold_rst_z", z_value, 0);
    check("hold_rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        xs[i] = 8'($urandom);
        ws[i] = 8'($urandom);
      end
      run_eval("rand", b, xs, ws, model_z(b, xs, ws), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4: number of x*w pairs per neuron evaluation (2..16).
REQ-002 SHALL have parameter FRAC_BITS, default 4: fractional bits of the Q4.4 operand and result format.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: x/w/bias valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a pair this cycle.
REQ-008 SHALL have port x, input, 8 signed: activation operand, Q4.4.
REQ-009 SHALL have port w, input, 8 signed: weight operand, Q4.4.
REQ-010 SHALL have port bias, input, 8 signed: Q4.4 bias, sampled only with the first pair of an evaluation.
REQ-011 SHALL have port out_valid, output, 1: z_value valid.
REQ-012 SHALL have port out_ready, input, 1: downstream (activation LUT stage) accepts z_value.
REQ-013 SHALL have port z_value, output, 8 signed: Q4.4 pre-activation; [7:4] is the LUT address and [3:0] the interpolation remainder downstream.

Function
REQ-014 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL accept a pair on in_valid && in_ready; no acceptance otherwise, and no state change.
REQ-016 SHALL, on the first accepted pair (count=0), load acc = (bias <<< FRAC_BITS) + x*w; on later pairs, acc = acc + x*w.
REQ-017 SHALL form products as full 16-bit signed; acc width = 16 + clog2(N_INPUTS) + 1, which must never overflow.
REQ-018 SHALL, on accepting pair N_INPUTS, register z_value = fit8(acc_next >>> FRAC_BITS) (arithmetic shift, floor), set count=0 and enter HOLD; z_value is therefore valid 1 cycle after the last accept.
REQ-019 SHALL, in HOLD, keep z_value and out_valid stable until out_ready=1; on that cycle, return to ACCUM; in_ready becomes 1 on the next cycle (no same-cycle bypass).
REQ-020 SHALL keep z_value unchanged in ACCUM (last result retained).
REQ-021 SHALL ignore x/w/bias whenever in_ready=0.
REQ-022 SHALL implement count as a 0..N_INPUTS-1 counter that wraps to 0 only on the final accept.

Reset
REQ-023 SHALL, on rst_n=0 at any time (including mid-evaluation or in HOLD), asynchronously force state=ACCUM, count=0, acc=0, z_value=8'h00, out_valid=0, in_ready=1 after reset.
REQ-024 SHALL discard any partial sum on reset; the next accepted pair is treated as the first.

Configuration
REQ-025 SHALL use macro NEURON_MAC_SAT_EN: when defined, fit8 saturates to [-128, +127] (0x80..0x7F); when undefined, fit8 takes the low 8 bits (two's-complement wrap).

Structure
REQ-026 SHALL take Q-format constants (DATA_W=8, FRAC_BITS default, PROD_W=16) and the state enum from shared package nn_fixed_pkg.
REQ-027 SHALL put the shift-and-fit logic in a sub-module neuron_mac_fit (combinational, acc in, 8-bit out, honours NEURON_MAC_SAT_EN).

Verification
REQ-028 SHALL cover basic sum: bias=0x00, four pairs x=0x10,w=0x10 -> z_value=0x40, out_valid 1 cycle after 4th accept.
REQ-029 SHALL cover bias and fraction: bias=0x10, four pairs x=0x18,w=0x08 -> z_value=0x40.
REQ-030 SHALL cover overflow: bias=0, four pairs x=0x7F,w=0x7F -> 0x7F with NEURON_MAC_SAT_EN, 0xC0 without; negative: x=0x80,w=0x10 x4 -> 0x80 with macro.
REQ-031 SHALL cover floor rounding: bias=0, pairs (0xFF,0x01),(0,0),(0,0),(0,0) -> z_value=0xFF.
REQ-032 SHALL cover backpressure: out_ready low 3 cycles after result -> z_value/out_valid stable, in_ready=0, offered pairs not consumed; out_ready high -> ACCUM next cycle.
REQ-033 SHALL cover reset mid-evaluation: 2 pairs accepted, rst_n pulsed low -> out_valid=0, z_value=0x00; then four 1.0*1.0 pairs with bias=0 -> 0x40.
